pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer around the ID stage of the 5-stage RV32 core (opcodes 51 R, 3 LD, 35 ST, 99 BR).
//  - Tracks destination registers in flight (EX/MEM/WB); stalls PC/IF-ID and injects ID/EX bubbles on RAW hazards.
//  - Flushes wrong-path instructions after a taken branch.
//  - Sits between fetch, the IF/ID register and the decoder.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles IF/ID is killed after a taken branch (1..15)
//  CNT_W         16  width of the saturating stall-cycle counter
// PORTS
//  clk           in   1      core clock, rising edge
//  reset         in   1      asynchronous, active-high
//  ifid_valid    in   1      IF/ID holds a real instruction
//  ifid_instr    in   32     ifid_reg[31:0]; opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20]
//  branch_taken  in   1      from EX; valid only while the EX-stage entry is a branch
//  pc_we         out  1      PC register write enable
//  ifid_we       out  1      IF/ID register write enable
//  ifid_flush    out  1      clear IF/ID valid on next edge
//  idex_bubble   out  1      load NOP into ID/EX instead of the decoded instruction
//  issue         out  1      ID instruction advances into ID/EX this cycle
//  stall_count   out  CNT_W  saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Reset (async): state=RUN, flush counter=0, EX/MEM/WB tracking entries invalid, stall_count=0.
//    While reset is high: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, issue=0.
//  - Per-opcode classification:
//    R: rs1, rs2, writes rd.  LD: rs1, writes rd, is_load.  ST: rs1, rs2.  BR: rs1, rs2, is_branch.
//    Other: no sources, no write.  rd==0 never counts as a writer; rs==0 never hazards.
//  - Tracking entry per stage: {v, ld, br, wa}. Each edge: WB<=MEM, MEM<=EX, EX<=issued entry, or invalid on bubble.
//  - hazard: any used source of a valid ifid_instr equals wa of a valid writer entry (rule set by FORWARDING_EN).
//  - FSM RUN:
//    . take = branch_taken & EX.v & EX.br. Priority 1: pc_we=1, ifid_flush=1, idex_bubble=1, issue=0.
//      If FLUSH_CYCLES>1, go FLUSH with cnt=FLUSH_CYCLES-1.
//    . Else if hazard: pc_we=0, ifid_we=0, idex_bubble=1, issue=0, stall_count+=1 (saturates at all-ones).
//    . Else: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=~ifid_valid, issue=ifid_valid.
//  - FSM FLUSH:
//    . pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1, issue=0; hazards not evaluated; cnt-=1; at cnt==1 -> RUN.
//    . branch_taken is ignored in FLUSH because EX only holds bubbles.
//  - Outputs are combinational from state, tracking entries and inputs; zero-cycle stall decision.
//  - Stall + taken branch in the same cycle: the branch wins and the stalled instruction is flushed.
//  - branch_taken while EX is not a branch: ignored.
//  - Reset mid-stall or mid-flush: immediate return to reset values; no pending state survives.
// CONFIGURATION
//  FORWARDING_EN defined:
//    - Only load-use hazards stall: source matches EX entry with ld=1.
//    - Exactly one bubble per load-use pair.
//  FORWARDING_EN undefined:
//    - Any valid writer in EX, MEM or WB with a matching wa stalls.
//    - Register file is not write-through, so WB is included.
//    - Up to 3 bubbles per dependency.
// STRUCTURE
//  - Package riscv_pkg:
//    . OP_RTYPE=7'd51, OP_LOAD=7'd3, OP_STORE=7'd35, OP_BRANCH=7'd99.
//    . typedef track_entry_t {v, ld, br, wa[4:0]}; typedef enum {RUN, FLUSH} hz_state_t.
//  - Sub-module hazard_src_decode (combinational): ifid_instr -> uses_rs1, uses_rs2, writes_rd, is_load, is_branch, rs1, rs2, rd.
//    Instantiated once; the controller holds the FSM, tracking entries and counter.
// TESTING
//  1. FORWARDING_EN, LD x5,0(x1) then ADD x6,x5,x2 back-to-back
//     -> exactly 1 cycle with pc_we=0, idex_bubble=1; stall_count=1; ADD issues next cycle.
//  2. No FORWARDING_EN, ADD x5,.. then ADD x7,x5,x3 -> 3 stall cycles, then issue=1; stall_count=3.
//  3. ADD x0,x1,x2 then ADD x3,x0,x0 (both configs) -> no stall; issue=1 on consecutive cycles.
//  4. BEQ in EX with branch_taken=1, FLUSH_CYCLES=2
//     -> ifid_flush=1 for 2 cycles, issue=0 both; back to RUN; pc_we=1 throughout.
//  5. Load-use hazard in ID coincident with taken branch in EX
//     -> flush wins; stall_count unchanged; no bubble-stall cycle.
//  6. Assert reset during the FLUSH count -> outputs to reset values that cycle;
//     after release, RUN with empty tracking and no residual flush.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared opcodes, tracking-entry type and FSM states for the ID-stage hazard sequencer.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'd51;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;

  typedef struct packed {
    logic       v;
    logic       ld;
    logic       br;
    logic [4:0] wa;
  } track_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_t;

  localparam track_entry_t TRACK_EMPTY = '{v: 1'b0, ld: 1'b0, br: 1'b0, wa: 5'd0};

  // Non-writers carry wa=0, so the rs!=0 test also rejects them.
  function automatic logic src_match(input logic used, input logic [4:0] rs, input track_entry_t e);
    return used && (rs != 5'd0) && e.v && (e.wa == rs);
  endfunction

endpackage

// File: rtl/hazard_src_decode.sv
// Classifies the IF/ID instruction into register sources, destination and load/branch flags.
module hazard_src_decode
  import riscv_pkg::*;
(
  input  logic [31:0] ifid_instr,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        writes_rd,
  output logic        is_load,
  output logic        is_branch,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  logic unused_fields_s;

  assign rs1 = ifid_instr[19:15];
  assign rs2 = ifid_instr[24:20];
  assign rd  = ifid_instr[11:7];
  assign unused_fields_s = ^{ifid_instr[31:25], ifid_instr[14:12]};

  // Opcode classification; x0 as destination never counts as a write.
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    is_branch = 1'b0;
    case (ifid_instr[6:0])
      OP_RTYPE: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = (rd != 5'd0);
      end
      OP_LOAD: begin
        uses_rs1  = 1'b1;
        writes_rd = (rd != 5'd0);
        is_load   = 1'b1;
      end
      OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        is_branch = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage pipeline sequencer: RAW stalls, bubble injection and post-branch flush.
// Define FORWARDING_EN to restrict stalls to load-use hazards against the EX entry.
module pipe_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ifid_valid,
  input  logic [31:0]      ifid_instr,
  input  logic             branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             issue,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic         uses_rs1_s, uses_rs2_s, writes_rd_s, is_load_s, is_branch_s;
  logic [4:0]   rs1_s, rs2_s, rd_s;
  hz_state_t    state_r, next_state_s;
  logic [3:0]   flush_cnt_r;
  track_entry_t ex_r, mem_r, wb_r, issued_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic         take_s, hazard_s, stall_s;

  hazard_src_decode u_dec (
    .ifid_instr (ifid_instr),
    .uses_rs1   (uses_rs1_s),
    .uses_rs2   (uses_rs2_s),
    .writes_rd  (writes_rd_s),
    .is_load    (is_load_s),
    .is_branch  (is_branch_s),
    .rs1        (rs1_s),
    .rs2        (rs2_s),
    .rd         (rd_s)
  );

  assign take_s = branch_taken & ex_r.v & ex_r.br;
  assign stall_count = stall_cnt_r;

`ifdef FORWARDING_EN
  logic unused_track_s;
  assign unused_track_s = ^{wb_r};
  assign hazard_s = ifid_valid && ex_r.ld &&
                    (src_match(uses_rs1_s, rs1_s, ex_r) || src_match(uses_rs2_s, rs2_s, ex_r));
`else
  // Register file is not write-through, so WB still blocks a reader.
  assign hazard_s = ifid_valid &&
                    (src_match(uses_rs1_s, rs1_s, ex_r)  || src_match(uses_rs2_s, rs2_s, ex_r)  ||
                     src_match(uses_rs1_s, rs1_s, mem_r) || src_match(uses_rs2_s, rs2_s, mem_r) ||
                     src_match(uses_rs1_s, rs1_s, wb_r)  || src_match(uses_rs2_s, rs2_s, wb_r));
`endif

  assign stall_s = (state_r == RUN) && !take_s && hazard_s;

  // Entry that enters EX when the ID instruction issues.
  always_comb begin
    issued_s    = TRACK_EMPTY;
    issued_s.v  = 1'b1;
    issued_s.ld = is_load_s;
    issued_s.br = is_branch_s;
    issued_s.wa = writes_rd_s ? rd_s : 5'd0;
  end

  // State register, flush counter, tracking shift and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= RUN;
      flush_cnt_r <= 4'd0;
      ex_r        <= TRACK_EMPTY;
      mem_r       <= TRACK_EMPTY;
      wb_r        <= TRACK_EMPTY;
      stall_cnt_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (state_r == RUN && take_s)
        flush_cnt_r <= FLUSH_LOAD;
      else if (state_r == FLUSH)
        flush_cnt_r <= flush_cnt_r - 4'd1;
      else
        flush_cnt_r <= flush_cnt_r;
      ex_r  <= issue ? issued_s : TRACK_EMPTY;
      mem_r <= ex_r;
      wb_r  <= mem_r;
      if (stall_s && !(&stall_cnt_r))
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else
        stall_cnt_r <= stall_cnt_r;
    end
  end

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RUN: begin
        if (take_s && (FLUSH_CYCLES > 1)) next_state_s = FLUSH;
        else                              next_state_s = RUN;
      end
      FLUSH: begin
        if (flush_cnt_r == 4'd1) next_state_s = RUN;
        else                     next_state_s = FLUSH;
      end
      default: next_state_s = RUN;
    endcase
  end

  // Pipeline control outputs; a taken branch outranks a stall.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    issue       = 1'b0;
    if (reset) begin
      pc_we = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (take_s) begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end else if (hazard_s) begin
            ifid_flush = 1'b0;
          end else begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = ~ifid_valid;
            issue       = ifid_valid;
          end
        end
        FLUSH: begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
        default: begin
          pc_we = 1'b0;
        end
      endcase
    end
  end

endmodule
